// File: rtl/grant_scheduler.sv
// Sequential arbiter granting one shared resource to one of N requesters, with
// fixed-priority or round-robin selection, a hold-time limit and a release gap.
module grant_scheduler #(
   parameter int N        = 15,
   parameter int IDW      = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           mode,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id,
   output logic           busy,
   output logic           timeout
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam int            HW         = 8;
   localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
   localparam logic [N-1:0]  ONE_N      = {{(N-1){1'b0}}, 1'b1};

   logic [1:0]     state_q,     state_d;
   logic [N-1:0]   gnt_q,       gnt_d;
   logic [IDW-1:0] gnt_id_q,    gnt_id_d;
   logic [IDW-1:0] last_id_q,   last_id_d;
   logic [HW-1:0]  hold_cnt_q,  hold_cnt_d;
   logic           timeout_q,   timeout_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic           busy_q,      busy_d;

   logic [N-1:0]   low_req;
   logic [IDW-1:0] win_id;
   logic [N-1:0]   win_oh;
   logic           owner_req;
   logic           hold_limit;

   function automatic logic [IDW-1:0] highest(input logic [N-1:0] v);
      highest = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) highest = IDW'(i);
      end
   endfunction

   // Round-robin = highest request below last_id, else highest overall (wrap).
   // With mode = 0 the lower window is empty, which gives plain fixed priority.
   always_comb begin
      low_req = '0;
      for (int i = 0; i < N; i++) begin
         low_req[i] = req[i] & mode & (IDW'(i) < last_id_q);
      end
      win_id = (low_req != '0) ? highest(low_req) : highest(req);
      win_oh = ONE_N << win_id;
   end

   assign owner_req  = |(req & gnt_q);
   assign hold_limit = (hold_cnt_q == HOLD_LIMIT);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path through
      // the case statement leaves one unassigned and infers a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en && (req != '0)) begin
               state_d    = ST_GRANT;
               gnt_d      = win_oh;
               gnt_id_d   = win_id;
               hold_cnt_d = HW'(1);
            end
         end
         ST_GRANT: begin
            if (done || !owner_req || hold_limit) begin
               state_d    = ST_RELEASE;
               gnt_d      = '0;
               gnt_id_d   = '1;
               last_id_d  = gnt_id_q;
               hold_cnt_d = '0;
               timeout_d  = hold_limit & ~done & owner_req;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d  = ST_IDLE;
            gnt_d    = '0;
            gnt_id_d = '1;
         end
      endcase

      gnt_valid_d = (gnt_d != '0);
      busy_d      = (state_d != ST_IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '1;
         last_id_q   <= '0;
         hold_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         gnt_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         last_id_q   <= last_id_d;
         hold_cnt_q  <= hold_cnt_d;
         timeout_q   <= timeout_d;
         gnt_valid_q <= gnt_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_grant_scheduler.sv
// Directed and randomized bench for grant_scheduler, checked every cycle
// against an ownership-level reference model.
module tb_grant_scheduler;

   localparam int N        = 15;
   localparam int IDW      = 4;
   localparam int MAX_HOLD = 8;

   logic           clk  = 1'b0;
   logic           rst  = 1'b1;
   logic           en   = 1'b0;
   logic           mode = 1'b0;
   logic           done = 1'b0;
   logic [N-1:0]   req  = '0;
   logic [N-1:0]   gnt;
   logic           gnt_valid;
   logic [IDW-1:0] gnt_id;
   logic           busy;
   logic           timeout;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, for how long, and whether the
   // mandatory release cycle is in progress.
   int m_owner   = -1;
   int m_hold    = 0;
   int m_last    = 0;
   bit m_rel     = 1'b0;
   bit m_timeout = 1'b0;

   grant_scheduler #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Search order: last-1 down to 0, then wrap from N-1; fixed priority starts from 0.
   function automatic int pick(input logic [N-1:0] r, input bit m, input int last);
      int base = m ? last : 0;
      for (int k = 1; k <= N; k++) begin
         int idx = (base - k + N) % N;
         if (r[4'(idx)]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_hold    = 0;
      m_last    = 0;
      m_rel     = 1'b0;
      m_timeout = 1'b0;
   endtask

   task automatic model_update();
      if (m_owner >= 0) begin
         bit still_req = req[4'(m_owner)];
         if (done || !still_req || m_hold == MAX_HOLD) begin
            m_timeout = (m_hold == MAX_HOLD) && !done && still_req;
            m_last    = m_owner;
            m_owner   = -1;
            m_rel     = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (m_rel) begin
         m_rel     = 1'b0;
         m_timeout = 1'b0;
      end else if (en && req != '0) begin
         m_owner = pick(req, mode, m_last);
         m_hold  = 1;
      end
   endtask

   task automatic check_outputs(input string ph);
      logic [31:0] eg;
      logic [31:0] eid;
      eg  = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      eid = (m_owner >= 0) ? 32'(m_owner) : 32'd15;
      chk({ph, ".gnt"},       32'(gnt),       eg);
      chk({ph, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
      chk({ph, ".gnt_id"},    32'(gnt_id),    eid);
      chk({ph, ".busy"},      32'(busy),      32'((m_owner >= 0) || m_rel));
      chk({ph, ".timeout"},   32'(timeout),   32'(m_timeout));
   endtask

   task automatic step(input string ph, input logic [N-1:0] r, input logic e,
                       input logic m, input logic d);
      req  = r;
      en   = e;
      mode = m;
      done = d;
      @(posedge clk);
      model_update();
      #1;
      check_outputs(ph);
   endtask

   task automatic sync_reset(input string ph);
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs(ph);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int          seq[$];
      int          rr_exp[5] = '{4, 1, 0, 4, 1};
      int          gcnt;
      int          tcnt;
      logic [N-1:0] r;

      // Reset and idle with en low
      @(posedge clk);
      #1;
      model_reset();
      check_outputs("reset");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step("en_off", 15'h7FFF, 1'b0, 1'b0, 1'b0);
      chk("en_off_no_grant", 32'(gnt_valid), 32'd0);

      // Fixed priority, done on the 3rd grant cycle, then re-grant
      step("fixed", 15'h0006, 1'b1, 1'b0, 1'b0);
      chk("fixed_id", 32'(gnt_id), 32'd2);
      step("fixed", 15'h0006, 1'b1, 1'b0, 1'b0);
      step("fixed", 15'h0006, 1'b1, 1'b0, 1'b0);
      step("fixed", 15'h0006, 1'b1, 1'b0, 1'b1);
      step("fixed_gap", 15'h0006, 1'b1, 1'b0, 1'b0);
      chk("fixed_gap_gnt", 32'(gnt), 32'd0);
      step("fixed_regrant", 15'h0006, 1'b1, 1'b0, 1'b0);
      chk("fixed_regrant_id", 32'(gnt_id), 32'd2);
      step("fixed_end", 15'h0000, 1'b1, 1'b0, 1'b1);
      step("fixed_end", 15'h0000, 1'b1, 1'b0, 1'b0);

      // Round-robin rotation from last_id = 0
      sync_reset("rr_reset");
      for (int i = 0; i < 15; i++) begin
         step("rr", 15'h0013, 1'b1, 1'b1, 1'b1);
         if (gnt_valid) seq.push_back(int'(gnt_id));
      end
      chk("rr_count", 32'(seq.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_seq%0d", i), 32'(seq[i]), 32'(rr_exp[i]));
      step("rr_end", 15'h0000, 1'b1, 1'b0, 1'b0);
      step("rr_end", 15'h0000, 1'b1, 1'b0, 1'b0);

      // Hold timeout
      gcnt = 0;
      tcnt = 0;
      for (int i = 0; i < 10; i++) begin
         step("hold", 15'h0001, 1'b1, 1'b0, 1'b0);
         gcnt += int'(gnt_valid);
         tcnt += int'(timeout);
      end
      chk("hold_len", 32'(gcnt), 32'd8);
      chk("hold_timeout_pulses", 32'(tcnt), 32'd1);
      step("hold_idle", 15'h0000, 1'b1, 1'b0, 1'b0);

      // done coinciding with the hold limit: no timeout
      tcnt = 0;
      for (int i = 1; i <= 10; i++) begin
         step("hold_done", 15'h0001, 1'b1, 1'b0, (i == 9));
         tcnt += int'(timeout);
      end
      chk("hold_done_no_timeout", 32'(tcnt), 32'd0);
      step("hold_idle", 15'h0000, 1'b1, 1'b0, 1'b0);

      // Request withdrawal on grant cycle 2
      step("wd", 15'h0020, 1'b1, 1'b0, 1'b0);
      chk("wd_id", 32'(gnt_id), 32'd5);
      step("wd", 15'h0020, 1'b1, 1'b0, 1'b0);
      step("wd_drop", 15'h0000, 1'b1, 1'b0, 1'b0);
      chk("wd_gnt", 32'(gnt), 32'd0);
      chk("wd_timeout", 32'(timeout), 32'd0);
      step("wd_idle", 15'h0000, 1'b1, 1'b0, 1'b0);

      // en dropped mid-grant: grant completes, nothing new afterwards
      step("en_mid", 15'h0020, 1'b1, 1'b0, 1'b0);
      step("en_mid", 15'h0020, 1'b0, 1'b0, 1'b0);
      step("en_mid", 15'h0020, 1'b0, 1'b0, 1'b0);
      chk("en_mid_held", 32'(gnt), 32'h0020);
      step("en_mid_done", 15'h0020, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("en_mid_after", 15'h0020, 1'b0, 1'b0, 1'b0);
      chk("en_mid_no_regrant", 32'(gnt_valid), 32'd0);

      // Asynchronous reset during a grant, then round-robin from last_id = 0
      step("arst", 15'h0200, 1'b1, 1'b0, 1'b0);
      step("arst", 15'h0200, 1'b1, 1'b0, 1'b0);
      chk("arst_pre_id", 32'(gnt_id), 32'd9);
      #2;
      sync_reset("arst_async");
      step("arst_rr", 15'h0201, 1'b1, 1'b1, 1'b0);
      chk("arst_rr_id", 32'(gnt_id), 32'd9);
      step("arst_rr", 15'h0201, 1'b1, 1'b1, 1'b1);
      step("arst_rr", 15'h0000, 1'b1, 1'b1, 1'b0);

      // Randomized traffic
      r = 15'h0000;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 2) == 0) r = 15'(32'd1 << $urandom_range(0, N - 1));
            else                           r = 15'($urandom);
         end
         if (i == 300) begin
            #3;
            sync_reset("rand_reset");
         end
         step("rand", r, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
